// File: rtl/eth_dma_mem_responder.sv
// AXI4 INCR-burst memory responder for the Ethernet DMA master port, backed by a dual-port RAM.
// Optional build macro ETH_DMA_RESP_STATS_EN adds saturating burst/error statistics outputs.
module eth_dma_mem_responder #(
    parameter int unsigned dma_addr_bits  = 64,
    parameter int unsigned dma_word_bits  = 64,
    parameter int unsigned mem_words_log2 = 10
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [dma_addr_bits-1:0]   s_axi_awaddr,
    input  logic [7:0]                 s_axi_awlen,
    input  logic                       s_axi_awvalid,
    output logic                       s_axi_awready,
    input  logic [dma_word_bits-1:0]   s_axi_wdata,
    input  logic [dma_word_bits/8-1:0] s_axi_wstrb,
    input  logic                       s_axi_wlast,
    input  logic                       s_axi_wvalid,
    output logic                       s_axi_wready,
    output logic [1:0]                 s_axi_bresp,
    output logic                       s_axi_bvalid,
    input  logic                       s_axi_bready,
    input  logic [dma_addr_bits-1:0]   s_axi_araddr,
    input  logic [7:0]                 s_axi_arlen,
    input  logic                       s_axi_arvalid,
    output logic                       s_axi_arready,
    output logic [dma_word_bits-1:0]   s_axi_rdata,
    output logic [1:0]                 s_axi_rresp,
    output logic                       s_axi_rlast,
    output logic                       s_axi_rvalid,
    input  logic                       s_axi_rready
`ifdef ETH_DMA_RESP_STATS_EN
    ,
    output logic [31:0]                stat_wr_bursts,
    output logic [31:0]                stat_rd_bursts,
    output logic [31:0]                stat_errors
`endif
);

    localparam int unsigned STRB_W = dma_word_bits / 8;
    localparam int unsigned LB     = $clog2(STRB_W);
    localparam int unsigned IDX_HI = mem_words_log2 + LB;
    localparam int unsigned DEPTH  = 2 ** mem_words_log2;
    localparam logic [1:0]  RESP_OK    = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef logic [mem_words_log2-1:0] idx_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    function automatic logic addr_oor(input logic [dma_addr_bits-1:0] a);
        return (a >> IDX_HI) != '0;
    endfunction

    function automatic idx_t addr_idx(input logic [dma_addr_bits-1:0] a);
        return a[IDX_HI-1:LB];
    endfunction

    // ---------------- write channel ----------------
    wstate_t r_wstate, w_wstate_nxt;
    logic    r_awready, r_wready, r_bvalid;
    logic [1:0] r_bresp;
    idx_t    r_widx;
    logic [7:0] r_wlen;
    logic [8:0] r_wcnt;
    logic    r_werr;
    logic    w_aw_hs, w_w_hs, w_b_hs, w_burst_bad, w_mem_we;

    assign w_aw_hs = s_axi_awvalid & r_awready;
    assign w_w_hs  = s_axi_wvalid & r_wready;
    assign w_b_hs  = r_bvalid & s_axi_bready;

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_burst_bad  = r_werr | (r_wcnt != {1'b0, r_wlen});
        w_mem_we     = w_w_hs & ~r_werr;
        case (r_wstate)
            W_IDLE:  if (w_aw_hs) w_wstate_nxt = W_DATA;
            W_DATA:  if (w_w_hs && s_axi_wlast) w_wstate_nxt = W_RESP;
            W_RESP:  if (w_b_hs) w_wstate_nxt = W_IDLE;
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OK;
            r_widx    <= '0;
            r_wlen    <= '0;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
        end else begin
            r_wstate  <= w_wstate_nxt;
            r_awready <= (w_wstate_nxt == W_IDLE);
            r_wready  <= (w_wstate_nxt == W_DATA);
            r_bvalid  <= (w_wstate_nxt == W_RESP);
            if (w_aw_hs) begin
                r_widx <= addr_idx(s_axi_awaddr);
                r_wlen <= s_axi_awlen;
                r_wcnt <= '0;
                r_werr <= addr_oor(s_axi_awaddr);
            end
            if (w_w_hs) begin
                r_widx <= r_widx + 1'b1;
                if (r_wcnt != 9'h1FF) r_wcnt <= r_wcnt + 1'b1;
                if (s_axi_wlast) r_bresp <= w_burst_bad ? RESP_SLVERR : RESP_OK;
            end
        end
    end

    // ---------------- read channel ----------------
    rstate_t r_rstate, w_rstate_nxt;
    logic    r_arready;
    idx_t    r_ridx;
    logic [7:0] r_rrem;
    logic    r_rerr;
    logic    r_pend, r_pend_last;
    logic    r_rvalid, r_rlast;
    logic [1:0] r_rresp;
    logic [dma_word_bits-1:0] r_rdata;
    logic    r_sk_valid, r_sk_last;
    logic [dma_word_bits-1:0] r_sk_data;
    logic [dma_word_bits-1:0] r_ram_q;
    logic [dma_word_bits-1:0] w_land_data;
    logic [1:0] w_occ;
    logic    w_ar_hs, w_r_pop, w_issue, w_rd_en;
    idx_t    w_rd_idx;

    logic [dma_word_bits-1:0] r_mem [DEPTH];

    assign w_ar_hs     = s_axi_arvalid & r_arready;
    assign w_r_pop     = r_rvalid & s_axi_rready;
    assign w_land_data = r_rerr ? '0 : r_ram_q;

    // Items held after this edge; a RAM read is issued only if it is sure to find a slot.
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_occ    = {1'b0, r_rvalid} + {1'b0, r_sk_valid} + {1'b0, r_pend} - {1'b0, w_r_pop};
        w_issue  = (r_rstate == R_DATA) && (r_rrem != 8'd0) && (w_occ <= 2'd1);
        w_rd_en  = w_ar_hs | w_issue;
        w_rd_idx = w_ar_hs ? addr_idx(s_axi_araddr) : r_ridx;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
            R_DATA:  if (w_r_pop && r_rlast) w_rstate_nxt = R_IDLE;
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rstate    <= R_IDLE;
            r_arready   <= 1'b1;
            r_ridx      <= '0;
            r_rrem      <= '0;
            r_rerr      <= 1'b0;
            r_pend      <= 1'b0;
            r_pend_last <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
            r_rresp     <= RESP_OK;
            r_rdata     <= '0;
            r_sk_valid  <= 1'b0;
            r_sk_last   <= 1'b0;
            r_sk_data   <= '0;
        end else begin
            r_rstate  <= w_rstate_nxt;
            r_arready <= (w_rstate_nxt == R_IDLE);
            if (w_ar_hs) begin
                r_ridx <= addr_idx(s_axi_araddr) + 1'b1;
                r_rrem <= s_axi_arlen;
                r_rerr <= addr_oor(s_axi_araddr);
            end else if (w_issue) begin
                r_ridx <= r_ridx + 1'b1;
                r_rrem <= r_rrem - 1'b1;
            end
            r_pend      <= w_rd_en;
            r_pend_last <= w_ar_hs ? (s_axi_arlen == 8'd0) : (r_rrem == 8'd1);
            // Output register refills from skid first, then from the RAM; skid catches a stalled landing.
            if (w_r_pop || !r_rvalid) begin
                if (r_sk_valid) begin
                    r_rvalid   <= 1'b1;
                    r_rdata    <= r_sk_data;
                    r_rlast    <= r_sk_last;
                    r_rresp    <= r_rerr ? RESP_SLVERR : RESP_OK;
                    r_sk_valid <= r_pend;
                    r_sk_data  <= w_land_data;
                    r_sk_last  <= r_pend_last;
                end else if (r_pend) begin
                    r_rvalid <= 1'b1;
                    r_rdata  <= w_land_data;
                    r_rlast  <= r_pend_last;
                    r_rresp  <= r_rerr ? RESP_SLVERR : RESP_OK;
                end else begin
                    r_rvalid <= 1'b0;
                    r_rlast  <= 1'b0;
                end
            end else if (r_pend) begin
                r_sk_valid <= 1'b1;
                r_sk_data  <= w_land_data;
                r_sk_last  <= r_pend_last;
            end
        end
    end

    // Read-first RAM: a same-cycle write to the read index returns the old word.
    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi_wstrb[b]) r_mem[r_widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
            end
        end
        if (w_rd_en) r_ram_q <= r_mem[w_rd_idx];
    end

    assign s_axi_awready = r_awready;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_arready;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rlast   = r_rlast;
    assign s_axi_rresp   = r_rresp;

`ifdef ETH_DMA_RESP_STATS_EN
    logic [1:0]  w_err_inc;
    logic [32:0] w_err_sum;

    assign w_err_inc = {1'b0, w_b_hs && (r_bresp == RESP_SLVERR)}
                     + {1'b0, w_r_pop && (r_rresp == RESP_SLVERR)};
    assign w_err_sum = {1'b0, stat_errors} + 33'(w_err_inc);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stat_wr_bursts <= '0;
            stat_rd_bursts <= '0;
            stat_errors    <= '0;
        end else begin
            if (w_b_hs && (stat_wr_bursts != 32'hFFFF_FFFF)) stat_wr_bursts <= stat_wr_bursts + 1'b1;
            if (w_r_pop && r_rlast && (stat_rd_bursts != 32'hFFFF_FFFF)) stat_rd_bursts <= stat_rd_bursts + 1'b1;
            stat_errors <= w_err_sum[32] ? 32'hFFFF_FFFF : w_err_sum[31:0];
        end
    end
`endif

endmodule
